fft_reorder_ram: RTL and testbench

Parametrised complex-sample reorder buffer at the input of the FFT core. It collects frames of 2^LOG2N complex samples, writing each at a permuted address: natural order, full bit-reversal, or a one-bit rotate shuffle. It then streams the frame out in natural address order with a valid/ready handshake. Ping-pong banking, when compiled in, lets one frame be written while the previous one is read.

---
 rtl/fft_reorder_ram.sv | 131 +++++++++++++
 tb/tb_fft_reorder_ram.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_reorder_ram.sv
// fft_reorder_ram: complex-sample reorder buffer in front of the FFT core.
// Frames of 2^LOG2N samples are written at a permuted address (natural,
// bit-reversed or rotate-right-by-1) and streamed out in natural order with
// a valid/ready handshake.
// Optional feature macro: RAM_PINGPONG_EN (two banks so that one frame can be
// written while the previous one is read; otherwise a single bank).
module fft_reorder_ram #(
  parameter int WIDTH = 32,
  parameter int LOG2N = 5,
  parameter int MODE  = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ED,
  input  logic [WIDTH-1:0] DReal,
  input  logic [WIDTH-1:0] DImag,
  output logic             IREADY,
  input  logic             OREADY,
  output logic             VLD,
  output logic             SOF,
  output logic             EOF,
  output logic [WIDTH-1:0] DOReal,
  output logic [WIDTH-1:0] DOImag,
  output logic             OVR
);

  localparam int N = 1 << LOG2N;
`ifdef RAM_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam int AW = (NB == 2) ? LOG2N + 1 : LOG2N;
  localparam logic [LOG2N-1:0] LAST = '1;

  // Write-side address permutation selected by MODE.
  function automatic logic [LOG2N-1:0] perm(input logic [LOG2N-1:0] i);
    logic [LOG2N-1:0] r;
    r = i;
    if (MODE == 1) begin
      for (int b = 0; b < LOG2N; b++) r[b] = i[LOG2N-1-b];
    end else if (MODE == 2) begin
      r = {i[0], i[LOG2N-1:1]};
    end
    return r;
  endfunction

  logic [2*WIDTH-1:0] mem [NB*N];
  logic [NB-1:0]      full;
  logic               wbank, rbank;
  logic [LOG2N-1:0]   wcnt, raddr;
  logic [AW-1:0]      wa, ra;
  logic               clr, we, wr_last, fire, rd_last;

  // START behaves exactly like reset and also swallows a coincident ED.
  assign clr     = RST | START;
  assign IREADY  = ~full[wbank];
  assign we      = ED & IREADY & ~clr;
  assign wr_last = we & (wcnt == LAST);
  assign fire    = full[rbank] & (~VLD | OREADY) & ~clr;
  assign rd_last = fire & (raddr == LAST);

  // The bank bit only takes part in the RAM address when there are two banks.
  if (NB == 2) begin : g_pp
    assign wa = {wbank, perm(wcnt)};
    assign ra = {rbank, raddr};
  end else begin : g_sb
    assign wa = perm(wcnt);
    assign ra = raddr;
  end

  // Sample storage; contents survive reset.
  always_ff @(posedge CLK) begin
    if (we) mem[wa] <= {DReal, DImag};
  end

  // Write counter and write bank selection.
  always_ff @(posedge CLK) begin
    if (clr) begin
      wcnt  <= '0;
      wbank <= 1'b0;
    end else if (we) begin
      wcnt <= wcnt + 1'b1;
      if (wr_last && NB == 2) wbank <= ~wbank;
    end
  end

  // Per-bank full flags; a bank is set by its last write and cleared by its
  // last read, which can never coincide for the same bank.
  always_ff @(posedge CLK) begin
    if (clr) begin
      full <= '0;
    end else begin
      if (wr_last) full[wbank] <= 1'b1;
      if (rd_last) full[rbank] <= 1'b0;
    end
  end

  // Output register with handshake: load on fire, hold while stalled, go
  // idle when nothing is buffered and downstream has taken the last sample.
  always_ff @(posedge CLK) begin
    if (clr) begin
      VLD    <= 1'b0;
      SOF    <= 1'b0;
      EOF    <= 1'b0;
      DOReal <= '0;
      DOImag <= '0;
      raddr  <= '0;
      rbank  <= 1'b0;
    end else if (fire) begin
      {DOReal, DOImag} <= mem[ra];
      VLD   <= 1'b1;
      SOF   <= (raddr == '0);
      EOF   <= (raddr == LAST);
      raddr <= raddr + 1'b1;
      if (rd_last && NB == 2) rbank <= ~rbank;
    end else if (!full[rbank] && OREADY) begin
      VLD <= 1'b0;
      SOF <= 1'b0;
      EOF <= 1'b0;
    end
  end

  // Sticky overrun flag for samples dropped while the buffer was blocked.
  always_ff @(posedge CLK) begin
    if (clr)                OVR <= 1'b0;
    else if (ED && !IREADY) OVR <= 1'b1;
  end

endmodule

// File: tb/tb_fft_reorder_ram.sv
// Bench for fft_reorder_ram: three instances (MODE 0/1/2) share one stimulus
// stream; a frame-level reference model feeds per-instance expectation queues
// that a negedge monitor drains.
`timescale 1ns/1ps
module tb_fft_reorder_ram;
  localparam int W = 32;
  localparam int L = 5;
  localparam int N = 32;
`ifdef RAM_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  typedef struct packed {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         sof;
    logic         eof;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         START = 1'b0;
  logic         ED = 1'b0;
  logic         OREADY = 1'b1;
  logic [W-1:0] DReal = '0;
  logic [W-1:0] DImag = '0;
  logic [2:0]   iready, vld, sof, eof, ovr;
  logic [W-1:0] dor [3];
  logic [W-1:0] doi [3];

  always #5 CLK = ~CLK;

  for (genvar m = 0; m < 3; m++) begin : g_dut
    fft_reorder_ram #(.WIDTH(W), .LOG2N(L), .MODE(m)) dut (
      .CLK(CLK), .RST(RST), .START(START), .ED(ED),
      .DReal(DReal), .DImag(DImag), .IREADY(iready[m]), .OREADY(OREADY),
      .VLD(vld[m]), .SOF(sof[m]), .EOF(eof[m]),
      .DOReal(dor[m]), .DOImag(doi[m]), .OVR(ovr[m])
    );
  end

  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 0;
  exp_t q [3][$];
  logic [2*W-1:0] fbuf [N];
  int   nfull = 0, wcnt = 0, rcnt = 0;
  bit   ovld = 0, ovr_m = 0;

  task automatic check(input bit ok, input string nm, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Output position that input index k lands on.
  function automatic int perm_ref(input int mode, input int k);
    int r;
    r = k;
    if (mode == 1) begin
      r = 0;
      for (int b = 0; b < L; b++) if (((k >> b) & 1) != 0) r += 1 << (L - 1 - b);
    end else if (mode == 2) begin
      r = (k >> 1) + ((k & 1) << (L - 1));
    end
    return r;
  endfunction

  // Reference model: counts of stored frames and output-slot occupancy.
  initial begin : model
    exp_t tmp [N];
    bit   ir, fr;
    int   inc, dec, j;
    forever begin
      @(posedge CLK);
      if (RST || START) begin
        nfull = 0; wcnt = 0; rcnt = 0; ovld = 0; ovr_m = 0;
        for (int m = 0; m < 3; m++) q[m].delete();
      end else begin
        inc = 0; dec = 0;
        ir = (nfull < NB);
        fr = (nfull > 0) && (!ovld || OREADY);
        if (ED && !ir) ovr_m = 1;
        if (fr) begin
          ovld = 1;
          rcnt++;
          if (rcnt == N) begin rcnt = 0; dec = 1; end
        end else if (nfull == 0 && OREADY) begin
          ovld = 0;
        end
        if (ED && ir) begin
          fbuf[wcnt] = {DReal, DImag};
          wcnt++;
          if (wcnt == N) begin
            wcnt = 0; inc = 1;
            for (int md = 0; md < 3; md++) begin
              for (int k = 0; k < N; k++) begin
                j = perm_ref(md, k);
                tmp[j].re  = fbuf[k][2*W-1:W];
                tmp[j].im  = fbuf[k][W-1:0];
                tmp[j].sof = (j == 0);
                tmp[j].eof = (j == N - 1);
              end
              for (int p = 0; p < N; p++) q[md].push_back(tmp[p]);
            end
          end
        end
        nfull = nfull + inc - dec;
      end
    end
  end

  // Monitor: compare flags every cycle, data against the queue head whenever
  // VLD is up, and retire the head when downstream accepts it.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        for (int m = 0; m < 3; m++) begin
          check(iready[m] == (nfull < NB), "iready", 72'(iready[m]), 72'(nfull < NB));
          check(ovr[m] == ovr_m, "ovr", 72'(ovr[m]), 72'(ovr_m));
          check(vld[m] == ovld, "vld", 72'(vld[m]), 72'(ovld));
          if (vld[m]) begin
            if (q[m].size() == 0) begin
              check(1'b0, "unexpected_output", 72'({dor[m], doi[m], sof[m], eof[m]}), 72'(0));
            end else begin
              e = q[m][0];
              check({dor[m], doi[m], sof[m], eof[m]} == e, "data",
                    72'({dor[m], doi[m], sof[m], eof[m]}), 72'(e));
              if (OREADY) void'(q[m].pop_front());
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset(input string nm);
    for (int m = 0; m < 3; m++)
      check({vld[m], sof[m], eof[m], ovr[m], iready[m], dor[m], doi[m]} == {4'b0, 1'b1, 64'b0}, nm,
            72'({vld[m], sof[m], eof[m], ovr[m], iready[m], dor[m], doi[m]}), 72'({4'b0, 1'b1, 64'b0}));
  endtask

  task automatic write_frame(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      ED = 1'b1; DReal = W'(i); DImag = $urandom;
      tick();
    end
    ED = 1'b0;
  endtask

  initial begin : stim
    bit found;
    RST = 1'b1;
    tick();
    mon_en = 1;
    repeat (2) tick();
    RST = 1'b0;
    check_reset("reset_state");

    // Ramp frame; first VLD two edges after the last ED is driven.
    write_frame(N);
    @(negedge CLK);
    check(vld == 3'b000, "latency_early", 72'(vld), 72'(0));
    @(negedge CLK);
    check(vld == 3'b111, "latency_first_vld", 72'(vld), 72'(7));
    repeat (40) tick();

    // Backpressure at output sample 7 for 5 cycles.
    write_frame(N);
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (vld[0] && dor[0] == 7) found = 1;
      else tick();
    end
    check(found, "bp_reach_sample7", 72'(found), 72'(1));
    OREADY = 1'b0;
    repeat (5) tick();
    OREADY = 1'b1;
    repeat (40) tick();

    // Continuous ED for three frames plus margin.
    for (int i = 0; i < 3 * N + 8; i++) begin
      ED = 1'b1; DReal = $urandom; DImag = $urandom;
      tick();
    end
    ED = 1'b0;
    repeat (80) tick();
    check(ovr == ((NB == 1) ? 3'b111 : 3'b000), "ovr_after_stream", 72'(ovr), 72'((NB == 1) ? 7 : 0));
    START = 1'b1;
    tick();
    START = 1'b0;
    check_reset("start_clears_ovr");

    // START mid-frame after 10 writes, with a coincident ED that must vanish.
    write_frame(10);
    START = 1'b1; ED = 1'b1; DReal = $urandom;
    tick();
    START = 1'b0; ED = 1'b0;
    check_reset("start_midframe");
    write_frame(N);
    repeat (40) tick();

    // Randomised traffic with occasional restarts.
    for (int i = 0; i < 2000; i++) begin
      ED     = ($urandom_range(0, 9) < 7);
      OREADY = ($urandom_range(0, 9) < 7);
      START  = ($urandom_range(0, 599) == 0);
      DReal  = $urandom;
      DImag  = $urandom;
      tick();
    end
    START = 1'b0; ED = 1'b0; OREADY = 1'b1;
    repeat (80) tick();
    for (int m = 0; m < 3; m++)
      check(q[m].size() == 0, "drained", 72'(q[m].size()), 72'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
